// File: rtl/video_pkg.sv
// Shared encodings for the video filter pipeline address generators.
package video_pkg;
  localparam int ADR_AW = 10;

  typedef enum logic [1:0] {
    ADR_ZERO   = 2'd0,
    ADR_CLAMP  = 2'd1,
    ADR_WRAP   = 2'd2,
    ADR_MIRROR = 2'd3
  } adr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } seq_state_e;
endpackage

// File: rtl/window_adr_seq_if.sv
// Run control plus address-set handshake between column controller,
// tap-address sequencer and line-buffer read side.
interface window_adr_seq_if
  import video_pkg::*;
#(
  parameter int AW   = ADR_AW,
  parameter int TAPS = 11
);
  logic              start;
  logic [AW-1:0]     ref_in;
  logic [AW-1:0]     max;
  logic [AW-1:0]     len;
  logic [1:0]        mode;
  logic              ready;
  logic              adr_valid;
  logic [TAPS*AW-1:0] adr;
  logic [AW-1:0]     ref_out;
  logic              last;
  logic              busy;
  logic              done;

  modport master (
    output start, ref_in, max, len, mode, ready,
    input  adr_valid, adr, ref_out, last, busy, done
  );

  modport slave (
    input  start, ref_in, max, len, mode, ready,
    output adr_valid, adr, ref_out, last, busy, done
  );
endinterface

// File: rtl/tap_edge_map.sv
// One tap: reference + offset, folded back into 0..max by the edge policy.
module tap_edge_map
  import video_pkg::*;
#(
  parameter int AW = ADR_AW
) (
  input  logic [AW-1:0]        ref_col,
  input  logic signed [AW+1:0] offset,
  input  logic [AW-1:0]        max,
  input  logic [1:0]           mode,
  output logic [AW-1:0]        adr
);
  localparam logic signed [AW+1:0] ONE = (AW+2)'(1);

  logic signed [AW+1:0] s, mx, c;

  // Two guard bits keep ref+offset and every single correction exact.
  always_comb begin
    s   = $signed({2'b00, ref_col}) + offset;
    mx  = $signed({2'b00, max});
    c   = '0;
    adr = '0;
    if (!s[AW+1] && s <= mx) begin
      adr = s[AW-1:0];
    end else begin
      case (adr_mode_e'(mode))
        ADR_CLAMP:  c = s[AW+1] ? '0 : mx;
        ADR_WRAP:   c = s[AW+1] ? s + mx + ONE : s - mx - ONE;
        ADR_MIRROR: c = s[AW+1] ? -s : (mx <<< 1) - s;
        default:    c = '0;
      endcase
      // Only one correction is applied; anything still outside reads 0.
      if (!c[AW+1] && c <= mx) adr = c[AW-1:0];
    end
  end
endmodule

// File: rtl/window_adr_seq.sv
// Line-buffer tap-address sequencer: steps a reference column through a
// run and hands out one registered set of TAPS addresses per position.
module window_adr_seq
  import video_pkg::*;
#(
  parameter int AW     = ADR_AW,
  parameter int TAPS   = 11,
  parameter int CENTER = 0
) (
  input  logic             clk,
  input  logic             rst,
  window_adr_seq_if.slave  bus
);
  seq_state_e         state, state_n;
  logic [AW-1:0]      cnt, cnt_n, p_max, p_len, ref_r;
  logic [1:0]         p_mode;
  logic [TAPS*AW-1:0] adr_r, map_adr;
  logic               valid_r, valid_n, last_r, last_n, done_r, done_n;
  logic               load, accept, xfer;
  logic [AW-1:0]      map_ref, map_max;
  logic [1:0]         map_mode;

  assign accept = (state == ST_IDLE) && bus.start;
  assign xfer   = valid_r && bus.ready;

  // The first set comes straight from the start inputs; later sets use the
  // latched run parameters and the next column.
  assign map_ref  = (state == ST_IDLE) ? bus.ref_in : ref_r + 1'b1;
  assign map_max  = (state == ST_IDLE) ? bus.max    : p_max;
  assign map_mode = (state == ST_IDLE) ? bus.mode   : p_mode;

  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    tap_edge_map #(.AW(AW)) u_map (
      .ref_col (map_ref),
      .offset  ((AW+2)'(i - ((CENTER != 0) ? (TAPS - 1) / 2 : 0))),
      .max     (map_max),
      .mode    (map_mode),
      .adr     (map_adr[i*AW +: AW])
    );
  end

  // Next state, load strobe and handshake flags.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    valid_n = valid_r;
    last_n  = last_r;
    done_n  = 1'b0;
    load    = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) begin
        load    = 1'b1;
        cnt_n   = '0;
        valid_n = 1'b1;
        last_n  = (bus.len == '0);
        state_n = (bus.len == '0) ? ST_LAST : ST_RUN;
      end
      ST_RUN: if (xfer) begin
        load  = 1'b1;
        cnt_n = cnt + 1'b1;
        if (cnt_n == p_len) begin
          last_n  = 1'b1;
          state_n = ST_LAST;
        end
      end
      ST_LAST: if (xfer) begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, run parameters and the registered output set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      p_max   <= '0;
      p_len   <= '0;
      p_mode  <= '0;
      ref_r   <= '0;
      adr_r   <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      valid_r <= valid_n;
      last_r  <= last_n;
      done_r  <= done_n;
      if (accept) begin
        p_max  <= bus.max;
        p_len  <= bus.len;
        p_mode <= bus.mode;
      end
      if (load) begin
        ref_r <= map_ref;
        adr_r <= map_adr;
      end
    end
  end

  assign bus.adr_valid = valid_r;
  assign bus.adr       = adr_r;
  assign bus.ref_out   = ref_r;
  assign bus.last      = last_r;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_r;
endmodule

// File: tb/tb_window_adr_seq.sv
// Randomised run bench for window_adr_seq: one uncentred and one centred
// instance driven in lockstep, each set checked against a tap model.
module tb_window_adr_seq;
  import video_pkg::*;
  localparam int AW   = 10;
  localparam int TAPS = 11;
  localparam int HALF = (TAPS - 1) / 2;
  localparam int MASK = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window_adr_seq_if #(.AW(AW), .TAPS(TAPS)) b0 ();
  window_adr_seq_if #(.AW(AW), .TAPS(TAPS)) b1 ();

  window_adr_seq #(.AW(AW), .TAPS(TAPS), .CENTER(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  window_adr_seq #(.AW(AW), .TAPS(TAPS), .CENTER(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_vec = 0;
  int n_bad = 0;
  logic [TAPS*AW-1:0] cap0, cap1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Edge policy straight from the address rules, in plain integers.
  function automatic int model_tap(input int r, input int o, input int mx, input int md);
    int s, c;
    s = r + o;
    if (s >= 0 && s <= mx) return s;
    case (md)
      0:       c = 0;
      1:       c = (s < 0) ? 0 : mx;
      2:       c = (s < 0) ? s + mx + 1 : s - (mx + 1);
      default: c = (s < 0) ? -s : 2 * mx - s;
    endcase
    return (c >= 0 && c <= mx) ? c : 0;
  endfunction

  task automatic drive(input bit st, input int r, input int m, input int l, input int md,
                       input bit rdy);
    b0.start = st;  b1.start = st;
    b0.ref_in = r[AW-1:0];  b1.ref_in = r[AW-1:0];
    b0.max = m[AW-1:0];     b1.max = m[AW-1:0];
    b0.len = l[AW-1:0];     b1.len = l[AW-1:0];
    b0.mode = md[1:0];      b1.mode = md[1:0];
    b0.ready = rdy;         b1.ready = rdy;
  endtask

  task automatic check_set(input int r, input int m, input int md, input bit lst);
    chk("valid0", b0.adr_valid, 1);
    chk("valid1", b1.adr_valid, 1);
    chk("ref0", b0.ref_out, r);
    chk("ref1", b1.ref_out, r);
    chk("last0", b0.last, lst);
    chk("last1", b1.last, lst);
    chk("done_in_run", b0.done | b1.done, 0);
    chk("busy_in_run", b0.busy & b1.busy, 1);
    for (int i = 0; i < TAPS; i++) begin
      chk($sformatf("adr0[%0d]", i), b0.adr[i*AW +: AW], model_tap(r, i, m, md));
      chk($sformatf("adr1[%0d]", i), b1.adr[i*AW +: AW], model_tap(r, i - HALF, m, md));
    end
  endtask

  // rk: 0 ready always high, 1 random ready, 2 ready low for two cycles first.
  task automatic run(input int r, input int m, input int l, input int md, input int rk);
    int k, cyc;
    bit rdy;
    @(negedge clk);
    chk("idle_busy", b0.busy | b1.busy, 0);
    drive(1'b1, r, m, l, md, 1'b0);
    @(negedge clk);
    k = 0;
    cyc = 0;
    while (k <= l && cyc < 200) begin
      check_set((r + k) & MASK, m, md, k == l);
      if (cyc == 0) begin
        cap0 = b0.adr;
        cap1 = b1.adr;
      end
      rdy = (rk == 0) ? 1'b1 : (rk == 1) ? 1'($urandom_range(0, 1)) : (cyc >= 2);
      // Starts with fresh parameters while busy must be ignored.
      drive(($urandom_range(0, 3) == 0), $urandom_range(0, MASK), $urandom_range(0, MASK),
            $urandom_range(0, 7), $urandom_range(0, 3), rdy);
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) chk("run_timeout", cyc, 0);
    chk("done0", b0.done, 1);
    chk("done1", b1.done, 1);
    chk("busy_at_done", b0.busy | b1.busy, 0);
    chk("valid_at_done", b0.adr_valid | b1.adr_valid, 0);
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    chk("done_single", b0.done | b1.done, 0);
  endtask

  task automatic chk_cap(input string tag, input logic [TAPS*AW-1:0] cap, input int e[TAPS]);
    for (int i = 0; i < TAPS; i++)
      chk($sformatf("%s[%0d]", tag, i), cap[i*AW +: AW], e[i]);
  endtask

  initial begin
    int e[TAPS];
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_valid", b0.adr_valid | b1.adr_valid, 0);
    chk("rst_busy", b0.busy | b1.busy, 0);
    chk("rst_adr", b0.adr | b1.adr, 0);
    chk("rst_ref", b0.ref_out | b1.ref_out, 0);
    chk("rst_last_done", b0.last | b0.done | b1.last | b1.done, 0);
    rst = 1'b0;

    run(636, 639, 0, 0, 0);
    e = '{636, 637, 638, 639, 0, 0, 0, 0, 0, 0, 0};
    chk_cap("zero", cap0, e);
    run(2, 639, 0, 1, 0);
    e = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7};
    chk_cap("clamp", cap1, e);
    run(1, 9, 0, 2, 0);
    e = '{6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 6};
    chk_cap("wrap", cap1, e);
    run(638, 639, 0, 3, 0);
    e = '{633, 634, 635, 636, 637, 638, 639, 638, 637, 636, 635};
    chk_cap("mirror", cap1, e);

    run(100, 639, 3, 0, 2);
    run(1022, 1023, 3, 3, 1);

    // Reset in the middle of a run clears everything at once.
    @(negedge clk);
    drive(1'b1, 50, 639, 5, 2, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", b0.adr_valid | b1.adr_valid, 0);
    chk("mid_rst_busy", b0.busy | b1.busy, 0);
    chk("mid_rst_adr", b0.adr | b1.adr, 0);
    chk("mid_rst_ref", b0.ref_out | b1.ref_out, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 30; n++)
      run($urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 6),
          $urandom_range(0, 3), $urandom_range(0, 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/window_adr_seq.md
# window_adr_seq

Sequenced, parametrised line-buffer tap-address generator for the video filter pipeline. After a `start`, it steps a reference column through a run of positions. For each position it emits one registered set of TAPS read addresses (ref+offset), with a selectable edge policy: zero, clamp, wrap or mirror. Address sets are handed to the line-buffer read side over a valid/ready handshake. It sits between the pixel-column controller and the line-buffer RAM read ports.

## Interface
- `AW`, 10, address/column width
- `TAPS`, 11, addresses per set; must be ≥1, and odd when CENTER=1
- `CENTER`, 0, 0: offsets 0..TAPS-1; 1: offsets -(TAPS-1)/2..+(TAPS-1)/2
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a run; accepted only in IDLE
- `ref_in`  in  AW  first reference column, sampled on accepted start
- `max`  in  AW  last legal address, sampled on accepted start
- `len`  in  AW  sets in run minus one, sampled on accepted start
- `mode`  in  2  0 ZERO, 1 CLAMP, 2 WRAP, 3 MIRROR; sampled on accepted start
- `ready`  in  1  downstream accepts current set
- `adr_valid`  out  1  `adr`/`ref_out`/`last` hold a valid set
- `adr`  out  TAPS*AW  flat tap addresses; tap i at bits [i*AW +: AW]
- `ref_out`  out  AW  reference column of the current set
- `last`  out  1  current set is the final one of the run
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse after the final transfer

## Operation
- States are IDLE, RUN and LAST.
  - IDLE + `start`: latch the parameters and load the set for `ref_in`. Go to LAST if `len`=0, else RUN.
  - RUN: on a transfer (`adr_valid`&&`ready`), load the set for `ref_out`+1 (mod 2^AW) and increment the counter. When the newly loaded set is number `len`, set `last` and go to LAST.
  - LAST: on transfer, clear `adr_valid`, pulse `done`, and return to IDLE.
- Tap math: offset o_i = i − (CENTER ? (TAPS−1)/2 : 0). Compute s = ref + o_i signed in AW+2 bits. The tap is in range iff 0 ≤ s ≤ max; in-range taps output s. Out-of-range taps follow the mode:
  - ZERO: output 0.
  - CLAMP: output 0 if s<0, else `max`.
  - WRAP: output s+max+1 if s<0, else s−(max+1).
  - MIRROR: output −s if s<0, else 2·max−s.
- WRAP and MIRROR apply exactly one correction. If the result is still outside 0..max, the tap outputs 0.
- `start` while busy is ignored. The latched parameters are not affected by input changes mid-run.
- `adr`, `ref_out` and `last` stay stable while `adr_valid`&&!`ready`.

## Timing
- Reset values: state IDLE; `adr_valid`, `busy`, `last` and `done` are 0; `adr` and `ref_out` are all zero; internal counter and latched parameters are 0.
- Latency:
  - `start` accepted at edge t → first set valid from t+1.
  - With `ready` held high, one set is produced per cycle, so a run of N sets occupies N cycles.
  - `done` is high during the cycle after the final transfer edge.
  - `busy` falls together with `done` rising. A new `start` can be accepted in that same `done` cycle.
- `rst` asserted mid-run forces reset values asynchronously; no partial set is held.
- Outputs are fully registered; no combinational path from `ready` to `adr`.

## Structure
- Shared package `video_pkg` holds:
  - mode encodings `ADR_ZERO`/`ADR_CLAMP`/`ADR_WRAP`/`ADR_MIRROR`
  - state encoding
  - default `AW`
- Sub-module `tap_edge_map`: combinational, one instance per tap via generate. It takes ref, offset, max and mode and returns one AW-bit address.
- Top level holds the FSM, the run counter and the output registers.

## Test plan
- ZERO, TAPS=11, CENTER=0, ref_in=636, max=639, len=0, ready=1 → one set: 636,637,638,639,0×7; `last`=1; `done` one cycle after the transfer.
- CLAMP, CENTER=1, ref_in=2, max=639 → 0,0,0,0,1,2,3,4,5,6,7.
- WRAP, CENTER=1, ref_in=1, max=9 → 6,7,8,9,0,1,2,3,4,5,6.
- MIRROR, CENTER=1, ref_in=638, max=639 → 633..639,638,637,636,635.
- Backpressure: ref_in=100, len=3, `ready` low for 2 cycles after the first valid → `adr` held stable; `ref_out` sequence 100,101,102,103 with no skip or duplicate; `last` only on 103; single `done`.
- `rst` pulse during RUN → `adr_valid`/`busy`=0 and `adr`=0 immediately. A `start` asserted while busy leaves the latched parameters and `ref_out` unchanged.
